// File: rtl/fetch_queue_stage_if.sv
// Bus bundle between the fetch queue stage and its neighbours: redirect, BTB,
// instruction memory and the decode-side handshake. The master is the stage.
interface fetch_queue_stage_if #(
  parameter int XLEN = 32
);
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] btb_target_pc;
  logic            btb_pc_valid;
  logic            btb_pc_predictTaken;
  logic [XLEN-1:0] fetch_pc;
  logic            imem_req_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_pc;
  logic            out_pred_taken;

  modport master (
    input  redirect_en, redirect_pc, btb_target_pc, btb_pc_valid,
           btb_pc_predictTaken, imem_rdata, out_ready,
    output fetch_pc, imem_req_en, imem_addr, out_valid, out_instruction,
           out_pc, out_pred_taken
  );

  modport slave (
    output redirect_en, redirect_pc, btb_target_pc, btb_pc_valid,
           btb_pc_predictTaken, imem_rdata, out_ready,
    input  fetch_pc, imem_req_en, imem_addr, out_valid, out_instruction,
           out_pc, out_pred_taken
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end with a decoupling queue toward decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: empty-queue responses go straight to decode.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_queue_stage_if.master       bus,
  output logic [$clog2(FQ_DEPTH):0] dbg_count_o,
  output logic                      dbg_inflight_o
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred;
  } fq_entry_t;

  fq_entry_t       mem_q [FQ_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d, reserved;
  logic [XLEN-1:0] pc_q, pc_d, infl_pc_q;
  logic            infl_q, infl_pred_q;
  logic            btb_taken, fifo_empty, resp_valid, bypass_hit;
  logic            pop_out, fifo_pop, push, issue;

  // Decode handshake: an entry transfers on a cycle where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_ready only steers pop/issue.
  always_comb begin
    btb_taken  = bus.btb_pc_valid && bus.btb_pc_predictTaken;
    fifo_empty = (count_q == '0);
    resp_valid = infl_q && !rst && !bus.redirect_en;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_hit = resp_valid && fifo_empty;
`else
    bypass_hit = 1'b0;
`endif
    bus.out_valid = !fifo_empty || bypass_hit;
    if (bypass_hit) begin
      bus.out_instruction = bus.imem_rdata;
      bus.out_pc          = infl_pc_q;
      bus.out_pred_taken  = infl_pred_q;
    end else begin
      bus.out_instruction = mem_q[rd_ptr_q].instr;
      bus.out_pc          = mem_q[rd_ptr_q].pc;
      bus.out_pred_taken  = mem_q[rd_ptr_q].pred;
    end
    pop_out  = bus.out_valid && bus.out_ready;
    fifo_pop = pop_out && !fifo_empty;
    push     = resp_valid && !(bypass_hit && bus.out_ready);
    // Slots already owed to queued entries and the outstanding response.
    reserved = count_q + CW'(infl_q) - CW'(pop_out);
    issue    = !rst && !bus.redirect_en && (reserved < CW'(FQ_DEPTH));

    pc_d = pc_q;
    if (bus.redirect_en)  pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)       pc_d = btb_taken ? bus.btb_target_pc : pc_q + XLEN'(4);

    count_d = count_q;
    if (push && !fifo_pop)      count_d = count_q + CW'(1);
    else if (!push && fifo_pop) count_d = count_q - CW'(1);

    bus.fetch_pc    = pc_q;
    bus.imem_addr   = pc_q;
    bus.imem_req_en = issue;
    dbg_count_o     = count_q;
    dbg_inflight_o  = infl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_pred_q <= 1'b0;
      infl_pc_q   <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.redirect_en) begin
      pc_q     <= pc_d;
      infl_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      infl_q  <= issue;
      if (issue) begin
        infl_pc_q   <= pc_q;
        infl_pred_q <= btb_taken;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.imem_rdata, infl_pc_q, infl_pred_q};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: reset, streaming, backpressure, full
// push/pop, redirects, BTB-taken and PC wrap; works with or without bypass.
module tb_fetch_queue_stage;
  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dbg_count;
  logic        dbg_inflight;
  logic        btb_on = 1'b0;
  logic        btb_taken = 1'b0;
  logic [31:0] btb_hit_pc = '0;
  logic [31:0] btb_tgt = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_fetch10 = 0;
  int          f10_base;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_queue_stage_if #(.XLEN(XLEN)) fq_if ();

  fetch_queue_stage #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (fq_if),
    .dbg_count_o    (dbg_count),
    .dbg_inflight_o (dbg_inflight)
  );

  // BTB model keyed on the live fetch address.
  assign fq_if.btb_pc_valid        = btb_on && (fq_if.fetch_pc == btb_hit_pc);
  assign fq_if.btb_target_pc       = btb_tgt;
  assign fq_if.btb_pc_predictTaken = btb_taken;

  // One-cycle synchronous instruction memory.
  always @(posedge clk) begin
    if (rst) fq_if.imem_rdata <= '0;
    else if (fq_if.imem_req_en) fq_if.imem_rdata <= fq_if.imem_addr ^ MAGIC;
  end

  always @(negedge clk)
    if (fq_if.imem_req_en && fq_if.imem_addr == 32'h10) n_fetch10++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Three reset cycles; a redirect during reset must be ignored.
  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      rst = 1'b1;
      fq_if.out_ready   = 1'b0;
      fq_if.redirect_en = (i == 1);
      fq_if.redirect_pc = 32'h300;
      smp();
      if (i == 1) check_val("rst_redir_req", fq_if.imem_req_en, 0);
      if (i == 2) begin
        check_val("rst_fetch_pc", fq_if.fetch_pc, 0);
        check_val("rst_imem_addr", fq_if.imem_addr, 0);
        check_val("rst_req", fq_if.imem_req_en, 0);
        check_val("rst_valid", fq_if.out_valid, 0);
        check_val("rst_instr", fq_if.out_instruction, 0);
        check_val("rst_pc", fq_if.out_pc, 0);
        check_val("rst_pred", fq_if.out_pred_taken, 0);
        check_val("rst_count", dbg_count, 0);
        check_val("rst_inflight", dbg_inflight, 0);
      end
    end
    fq_if.redirect_en = 1'b0;
  endtask

  // Accept every expected entry on consecutive cycles (no gaps allowed).
  task automatic drain(input string tag);
    logic [32:0] e;
    while (exp_q.size() > 0) begin
      cyc();
      fq_if.out_ready = 1'b1;
      smp();
      e = exp_q.pop_front();
      check_val({tag, "_valid"}, fq_if.out_valid, 1);
      check_val({tag, "_pc"}, fq_if.out_pc, e[31:0]);
      check_val({tag, "_pred"}, fq_if.out_pred_taken, e[32]);
      check_val({tag, "_instr"}, fq_if.out_instruction, e[31:0] ^ MAGIC);
    end
  endtask

  task automatic wait_latency(input string tag);
    for (int i = 1; i < LAT; i++) begin
      cyc();
      smp();
      check_val(tag, fq_if.out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    fq_if.redirect_en = 1'b0;
    fq_if.redirect_pc = '0;
    fq_if.out_ready   = 1'b0;

    // Reset and streaming fetch.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc();
      rst = 1'b0;
      fq_if.out_ready = 1'b1;
      smp();
      check_val("t1_addr", fq_if.imem_addr, 32'(4 * k));
      check_val("t1_req", fq_if.imem_req_en, 1);
      check_val("t1_valid", fq_if.out_valid, (k >= LAT));
      if (k >= LAT) begin
        check_val("t1_pc", fq_if.out_pc, 32'(4 * (k - LAT)));
        check_val("t1_instr", fq_if.out_instruction, 32'(4 * (k - LAT)) ^ MAGIC);
      end
    end

    // Backpressure until full (mid-operation reset first).
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      rst = 1'b0;
      fq_if.out_ready = 1'b0;
      smp();
    end
    check_val("full_count", dbg_count, 4);
    check_val("full_req", fq_if.imem_req_en, 0);
    check_val("full_fetch_pc", fq_if.fetch_pc, 32'h10);
    check_val("full_valid", fq_if.out_valid, 1);
    check_val("full_head_pc", fq_if.out_pc, 0);
    f10_base = n_fetch10;

    // One-cycle pop at full: 0x10 issues into the freed slot.
    cyc();
    fq_if.out_ready = 1'b1;
    smp();
    check_val("pp_head_pc", fq_if.out_pc, 0);
    check_val("pp_req", fq_if.imem_req_en, 1);
    check_val("pp_addr", fq_if.imem_addr, 32'h10);
    cyc();
    fq_if.out_ready = 1'b0;
    smp();
    check_val("pp_count_mid", dbg_count, 3);
    check_val("pp_inflight", dbg_inflight, 1);
    check_val("pp_req_mid", fq_if.imem_req_en, 0);
    cyc();
    smp();
    check_val("pp_count_full", dbg_count, 4);
    check_val("pp_req_full", fq_if.imem_req_en, 0);
    check_val("pp_head_next", fq_if.out_pc, 4);
    exp_q.push_back({1'b0, 32'h4});
    exp_q.push_back({1'b0, 32'h8});
    exp_q.push_back({1'b0, 32'hC});
    exp_q.push_back({1'b0, 32'h10});
    exp_q.push_back({1'b0, 32'h14});
    exp_q.push_back({1'b0, 32'h18});
    drain("rel");
    check_val("fetch10_once", n_fetch10 - f10_base, 1);

    // Redirect with two queued and one in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      rst = 1'b0;
      fq_if.out_ready = 1'b0;
      smp();
    end
    cyc();
    fq_if.redirect_en = 1'b1;
    fq_if.redirect_pc = 32'h202;
    smp();
    check_val("rd_pre_count", dbg_count, 2);
    check_val("rd_pre_inflight", dbg_inflight, 1);
    check_val("rd_req", fq_if.imem_req_en, 0);
    cyc();
    fq_if.redirect_en = 1'b0;
    fq_if.out_ready = 1'b1;
    smp();
    check_val("rd_valid_after", fq_if.out_valid, 0);
    check_val("rd_count_after", dbg_count, 0);
    check_val("rd_fetch_pc", fq_if.fetch_pc, 32'h200);
    check_val("rd_req_after", fq_if.imem_req_en, 1);
    wait_latency("rd_lat_valid");
    exp_q.push_back({1'b0, 32'h200});
    exp_q.push_back({1'b0, 32'h204});
    exp_q.push_back({1'b0, 32'h208});
    drain("rd");

    // BTB taken at 0x8 toward 0x40.
    do_reset();
    btb_on = 1'b1;
    btb_hit_pc = 32'h8;
    btb_tgt = 32'h40;
    btb_taken = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      cyc();
      rst = 1'b0;
      fq_if.out_ready = 1'b1;
      smp();
      check_val("btb_lat_valid", fq_if.out_valid, 0);
      check_val("btb_addr", fq_if.imem_addr, 32'(4 * k));
    end
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h4});
    exp_q.push_back({1'b1, 32'h8});
    exp_q.push_back({1'b0, 32'h40});
    exp_q.push_back({1'b0, 32'h44});
    drain("btb");
    btb_on = 1'b0;

    // Redirect to the top of the address space; PC wraps to 0.
    cyc();
    fq_if.redirect_en = 1'b1;
    fq_if.redirect_pc = 32'hFFFF_FFFC;
    smp();
    check_val("wrap_req", fq_if.imem_req_en, 0);
    cyc();
    fq_if.redirect_en = 1'b0;
    smp();
    check_val("wrap_valid", fq_if.out_valid, 0);
    check_val("wrap_fetch_pc", fq_if.fetch_pc, 32'hFFFF_FFFC);
    wait_latency("wrap_lat_valid");
    exp_q.push_back({1'b0, 32'hFFFF_FFFC});
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h4});
    drain("wrap");

    // Redirect held for three cycles: no requests while held.
    for (int i = 0; i < 3; i++) begin
      cyc();
      fq_if.redirect_en = 1'b1;
      fq_if.redirect_pc = 32'h500;
      smp();
      check_val("hold_req", fq_if.imem_req_en, 0);
      if (i > 0) begin
        check_val("hold_valid", fq_if.out_valid, 0);
        check_val("hold_count", dbg_count, 0);
      end
    end
    cyc();
    fq_if.redirect_en = 1'b0;
    smp();
    check_val("hold_fetch_pc", fq_if.fetch_pc, 32'h500);
    check_val("hold_req_after", fq_if.imem_req_en, 1);
    check_val("hold_valid_after", fq_if.out_valid, 0);
    wait_latency("hold_lat_valid");
    exp_q.push_back({1'b0, 32'h500});
    exp_q.push_back({1'b0, 32'h504});
    drain("hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
